snake_control: RTL

- Control FSM that sequences the snake datapath (segment RAM, head register, food logic, pixel plotter) through one game step per move tick.
- Per move it reads the direction buttons, advances the head, checks food, shifts the body through the RAM, erases the old tail, redraws body and food, and checks for death.
- Sits between the board inputs (keys, start) and the datapath; it owns every datapath control strobe.

---
 rtl/snake_control.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_control.sv
// snake_control: game-step sequencer for the snake datapath.
// Drives every RAM, head, shift and plot strobe from one FSM.
module snake_control #(
    parameter int INIT_LEN  = 3,
    parameter int MAX_LEN   = 255,
    parameter int RAM_DEPTH = 2048,
    parameter int TICK_DIV  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       is_dead,
    input  logic       inc_length,
    output logic       reset_ram,
    output logic       ld_q_def,
    output logic       ld_head,
    output logic       rst_address,
    output logic       inc_address,
    output logic       update_head,
    output logic       check_inc,
    output logic       lock,
    output logic       ld_head_into_prev,
    output logic       ld_q_into_curr,
    output logic       ld_prev_into_q,
    output logic       ld_curr_into_prev,
    output logic       draw_q,
    output logic       draw_curr,
    output logic       food_en,
    output logic [3:0] cnt_status,
    output logic [2:0] dir,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int CW = $clog2(RAM_DEPTH + 1);
    localparam int TW = 23;

    localparam logic [2:0] D_UP    = 3'b100;
    localparam logic [2:0] D_DOWN  = 3'b110;
    localparam logic [2:0] D_LEFT  = 3'b000;
    localparam logic [2:0] D_RIGHT = 3'b001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_INIT,
        S_WAIT,
        S_UPDATE,
        S_CHECK,
        S_SHIFT,
        S_ERASE,
        S_DRAW,
        S_FOOD,
        S_DEAD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    ph_q, ph_d;
    logic [3:0]    pix_q, pix_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    dir_q, dir_d;
    logic [2:0]    pend_q, pend_d;

    logic          last_seg;

    assign last_seg = (seg_q == len_q - 8'd1);

    // State and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seg_q   <= '0;
            ph_q    <= '0;
            pix_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            ph_q    <= ph_d;
            pix_q   <= pix_d;
            tick_q  <= tick_d;
        end
    end

    // Next state: walk each phase by its sub-counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        ph_d    = ph_q;
        pix_d   = pix_q;
        tick_d  = tick_q;
        unique case (state_q)
            S_IDLE, S_DEAD: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CW'(RAM_DEPTH - 1)) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INIT: begin
                if (cnt_q == CW'(INIT_LEN)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    tick_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (is_dead) begin
                    state_d = S_DEAD;
                    tick_d  = '0;
                end else if (tick_q == TW'(TICK_DIV - 1)) begin
                    state_d = S_UPDATE;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_UPDATE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
                seg_d   = '0;
                ph_d    = '0;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else if (ph_q == 2'd2) begin
                    ph_d = '0;
                    if (last_seg) begin
                        state_d = S_ERASE;
                        pix_d   = '0;
                    end else begin
                        seg_d = seg_q + 8'd1;
                    end
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            S_ERASE: begin
                if (pix_q == 4'd15) begin
                    state_d = S_DRAW;
                    pix_d   = '0;
                    cnt_d   = '0;
                    seg_d   = '0;
                    ph_d    = '0;
                end else begin
                    pix_d = pix_q + 4'd1;
                end
            end
            S_DRAW: begin
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else if (pix_q == 4'd15) begin
                    pix_d = '0;
                    ph_d  = '0;
                    if (last_seg) begin
                        state_d = is_dead ? S_DEAD : S_FOOD;
                    end else begin
                        seg_d = seg_q + 8'd1;
                    end
                end else begin
                    pix_d = pix_q + 4'd1;
                end
            end
            S_FOOD: begin
                if (pix_q == 4'd15) begin
                    state_d = S_WAIT;
                    pix_d   = '0;
                end else begin
                    pix_d = pix_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore strobes decoded from state and sub-counters
    always_comb begin
        reset_ram         = 1'b0;
        ld_q_def          = 1'b0;
        ld_head           = 1'b0;
        rst_address       = 1'b0;
        inc_address       = 1'b0;
        update_head       = 1'b0;
        check_inc         = 1'b0;
        lock              = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        draw_q            = 1'b0;
        draw_curr         = 1'b0;
        food_en           = 1'b0;
        cnt_status        = '0;
        unique case (state_q)
            S_CLEAR: begin
                reset_ram   = 1'b1;
                inc_address = 1'b1;
                rst_address = (cnt_q == '0);
            end
            S_INIT: begin
                if (cnt_q == '0) begin
                    rst_address = 1'b1;
                end else begin
                    ld_q_def    = 1'b1;
                    inc_address = 1'b1;
                    ld_head     = (cnt_q == CW'(INIT_LEN));
                end
            end
            S_UPDATE: begin
                update_head = 1'b1;
                lock        = 1'b1;
            end
            S_CHECK: begin
                check_inc = 1'b1;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    ld_head_into_prev = 1'b1;
                    rst_address       = 1'b1;
                end else if (ph_q == 2'd1) begin
                    ld_q_into_curr = 1'b1;
                end else if (ph_q == 2'd2) begin
                    ld_prev_into_q    = 1'b1;
                    ld_curr_into_prev = 1'b1;
                    inc_address       = 1'b1;
                end
            end
            S_ERASE: begin
                draw_curr  = 1'b1;
                cnt_status = pix_q;
            end
            S_DRAW: begin
                if (cnt_q == '0) begin
                    rst_address = 1'b1;
                end else if (ph_q == 2'd1) begin
                    draw_q      = 1'b1;
                    cnt_status  = pix_q;
                    inc_address = (pix_q == 4'd15);
                end
            end
            S_FOOD: begin
                food_en    = 1'b1;
                cnt_status = pix_q;
            end
            default: begin
            end
        endcase
    end

    // Pending direction: priority pick, opposite of applied dir ignored
    always_comb begin
        pend_d = pend_q;
        if (btn_up && dir_q != D_DOWN) begin
            pend_d = D_UP;
        end else if (btn_down && dir_q != D_UP) begin
            pend_d = D_DOWN;
        end else if (btn_left && dir_q != D_RIGHT) begin
            pend_d = D_LEFT;
        end else if (btn_right && dir_q != D_LEFT) begin
            pend_d = D_RIGHT;
        end
        if (state_q == S_INIT) begin
            pend_d = D_RIGHT;
        end
    end

    // Game variables: length, score, applied direction
    always_comb begin
        len_d   = len_q;
        score_d = score_q;
        dir_d   = dir_q;
        if (state_q == S_CLEAR) begin
            len_d   = 8'(INIT_LEN);
            score_d = '0;
        end
        if (state_q == S_INIT) begin
            dir_d = D_RIGHT;
        end
        if (state_q == S_UPDATE) begin
            dir_d = pend_q;
        end
        if (state_q == S_CHECK && inc_length && len_q < 8'(MAX_LEN)) begin
            len_d   = len_q + 8'd1;
            score_d = score_q + 8'd1;
        end
    end

    // Game variable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= 8'(INIT_LEN);
            score_q <= '0;
            dir_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
        end else begin
            len_q   <= len_d;
            score_q <= score_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    assign dir       = dir_q;
    assign score     = score_q;
    assign game_over = (state_q == S_DEAD);

endmodule
